// File: rtl/pcf8591_scan.sv
// pcf8591_scan: round-robin PCF8591 ADC scanner driving i2c_dri, with DAC writes
// interleaved at most once per channel slot.
module pcf8591_scan #(
    parameter logic [15:0] SCAN_GAP = 16'd100,
    parameter logic [3:0]  CH_MASK  = 4'b1111,
    parameter logic [19:0] TIMEOUT  = 20'd500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        i2c_exec,
    output logic        i2c_rh_wl,
    output logic [15:0] i2c_addr,
    output logic [7:0]  i2c_data_w,
    input  logic [7:0]  i2c_data_r,
    input  logic        i2c_done,
    input  logic        dac_req,
    input  logic [7:0]  dac_data,
    output logic        dac_ack,
    output logic [31:0] adc_data,
    output logic [3:0]  adc_valid,
    output logic        busy,
    output logic        timeout_err
);
    typedef enum logic [2:0] {IDLE, GAP, DAC_WR, ADC_DUMMY, ADC_RD, WAIT_DONE} state_t;
    typedef enum logic [1:0] {OP_DAC, OP_DUMMY, OP_RD} op_t;
    state_t      r_state;
    op_t         r_op;
    logic [15:0] r_cnt;
    logic [19:0] r_tcnt;
    logic [1:0]  r_ch;
    logic        r_pend;
    logic        r_dac_done;
    logic [1:0]  w_first;
    logic [1:0]  w_next;
    logic        w_dac_ok;
    always_comb begin
        w_first  = CH_MASK[0] ? 2'd0 : CH_MASK[1] ? 2'd1 : CH_MASK[2] ? 2'd2 : CH_MASK[3] ? 2'd3 : 2'd0;
        w_next   = CH_MASK[r_ch + 2'd1] ? r_ch + 2'd1 :
                   CH_MASK[r_ch + 2'd2] ? r_ch + 2'd2 :
                   CH_MASK[r_ch + 2'd3] ? r_ch + 2'd3 : r_ch;
        // with no channels to scan the DAC may be served back to back
        w_dac_ok = dac_req && !(r_dac_done && CH_MASK != 4'd0);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op        <= OP_DAC;
            r_cnt       <= 16'd0;
            r_tcnt      <= 20'd0;
            r_ch        <= w_first;
            r_pend      <= 1'b0;
            r_dac_done  <= 1'b0;
            i2c_exec    <= 1'b0;
            i2c_rh_wl   <= 1'b0;
            i2c_addr    <= 16'd0;
            i2c_data_w  <= 8'd0;
            dac_ack     <= 1'b0;
            adc_data    <= 32'd0;
            adc_valid   <= 4'd0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            i2c_exec  <= 1'b0;
            dac_ack   <= 1'b0;
            adc_valid <= 4'd0;
            case (r_state)
                IDLE: r_state <= GAP;
                GAP: begin
                    r_cnt <= (r_cnt < SCAN_GAP) ? r_cnt + 16'd1 : 16'd0;
                    if (r_cnt >= SCAN_GAP) begin
                        if (r_pend) r_state <= ADC_RD;
                        else if (w_dac_ok) r_state <= DAC_WR;
                        else if (CH_MASK != 4'd0) begin
                            r_state    <= ADC_DUMMY;
                            r_dac_done <= 1'b0;
                        end
                    end
                end
                DAC_WR: begin
                    i2c_exec   <= 1'b1;
                    i2c_rh_wl  <= 1'b0;
                    i2c_addr   <= 16'h0040;
                    i2c_data_w <= dac_data;
                    busy       <= 1'b1;
                    r_op       <= OP_DAC;
                    r_tcnt     <= 20'd0;
                    r_state    <= WAIT_DONE;
                end
                ADC_DUMMY, ADC_RD: begin
                    i2c_exec  <= 1'b1;
                    i2c_rh_wl <= 1'b1;
                    i2c_addr  <= {8'h00, 6'b010000, r_ch};
                    busy      <= 1'b1;
                    r_op      <= (r_state == ADC_RD) ? OP_RD : OP_DUMMY;
                    r_tcnt    <= 20'd0;
                    r_state   <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (i2c_done) begin
                        busy    <= 1'b0;
                        r_state <= GAP;
                        r_pend  <= (r_op == OP_DUMMY);
                        if (r_op == OP_DAC) begin
                            dac_ack    <= 1'b1;
                            r_dac_done <= 1'b1;
                        end
                        if (r_op == OP_RD) begin
                            adc_data[{r_ch, 3'b000} +: 8] <= i2c_data_r;
                            adc_valid[r_ch]               <= 1'b1;
                            r_ch                          <= w_next;
                        end
                    end else if (r_tcnt == TIMEOUT - 20'd1) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        r_pend      <= 1'b0;
                        r_state     <= GAP;
                    end else r_tcnt <= r_tcnt + 20'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pcf8591_scan.sv
// tb_pcf8591_scan: directed/randomised checks of pcf8591_scan against an I2C BFM
// and a transaction-level model of the expected scan order.
module tb_pcf8591_scan;
    logic        clk;
    logic        rst_n;
    logic        dac_req;
    logic [7:0]  dac_data;
    logic        a_exec, a_rh, a_done, a_ack, a_busy, a_to;
    logic [15:0] a_addr;
    logic [7:0]  a_dw, a_rd;
    logic [31:0] a_adc;
    logic [3:0]  a_valid;
    logic        b_exec, b_rh, b_done, b_ack, b_busy, b_to;
    logic [15:0] b_addr;
    logic [7:0]  b_dw, b_rd;
    logic [31:0] b_adc;
    logic [3:0]  b_valid;
    logic        b_req;
    logic [7:0]  b_dac;

    pcf8591_scan #(.SCAN_GAP(16'd4), .CH_MASK(4'b1111), .TIMEOUT(20'd50)) dut (
        .clk(clk), .rst_n(rst_n), .i2c_exec(a_exec), .i2c_rh_wl(a_rh), .i2c_addr(a_addr),
        .i2c_data_w(a_dw), .i2c_data_r(a_rd), .i2c_done(a_done), .dac_req(dac_req),
        .dac_data(dac_data), .dac_ack(a_ack), .adc_data(a_adc), .adc_valid(a_valid),
        .busy(a_busy), .timeout_err(a_to));

    pcf8591_scan #(.SCAN_GAP(16'd4), .CH_MASK(4'b1010), .TIMEOUT(20'd50)) dut_b (
        .clk(clk), .rst_n(rst_n), .i2c_exec(b_exec), .i2c_rh_wl(b_rh), .i2c_addr(b_addr),
        .i2c_data_w(b_dw), .i2c_data_r(b_rd), .i2c_done(b_done), .dac_req(b_req),
        .dac_data(b_dac), .dac_ack(b_ack), .adc_data(b_adc), .adc_valid(b_valid),
        .busy(b_busy), .timeout_err(b_to));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        rh;
        logic [7:0]  dw;
        int          cyc;
    } ex_t;

    ex_t        log_a[$];
    ex_t        log_b[$];
    logic [3:0] vq_a[$];
    int         ack_a = 0, cyc = 0, bad_a = 0, bad_b = 0;
    int         bv_cnt[4] = '{0, 0, 0, 0};
    logic       pb_a = 1'b0, pb_b = 1'b0;
    logic [24:0] last_a = '0;
    logic [7:0] ain[4];
    logic [7:0] bin[4];
    int         lat = 3;
    logic       hold = 1'b0;
    logic [1:0] ch_a, ch_b;
    int         checks = 0, errors = 0;

    // monitor: logs transactions and flags exec-while-busy or unstable request fields
    always begin
        @(posedge clk); #1;
        cyc++;
        if (a_exec) begin
            log_a.push_back('{addr: a_addr, rh: a_rh, dw: a_dw, cyc: cyc});
            if (!a_busy || pb_a) bad_a++;
            last_a = {a_addr, a_rh, a_dw};
        end else if (a_busy && last_a != {a_addr, a_rh, a_dw}) bad_a++;
        if (b_exec) begin
            log_b.push_back('{addr: b_addr, rh: b_rh, dw: b_dw, cyc: cyc});
            if (!b_busy || pb_b) bad_b++;
        end
        if (a_valid != 4'd0) vq_a.push_back(a_valid);
        if (a_ack) ack_a++;
        for (int k = 0; k < 4; k++) if (b_valid[k]) bv_cnt[k]++;
        pb_a = a_busy;
        pb_b = b_busy;
    end

    always begin
        @(posedge clk); #1;
        if (a_exec) begin
            ch_a = a_addr[1:0];
            repeat (lat) begin @(posedge clk); #1; end
            if (!hold) begin
                a_rd = ain[ch_a];
                a_done = 1'b1;
                @(posedge clk); #1;
                a_done = 1'b0;
            end
        end
    end

    always begin
        @(posedge clk); #1;
        if (b_exec) begin
            ch_b = b_addr[1:0];
            repeat (3) begin @(posedge clk); #1; end
            b_rd = bin[ch_b];
            b_done = 1'b1;
            @(posedge clk); #1;
            b_done = 1'b0;
        end
    end

    function automatic int nxt(input int c, input logic [3:0] m);
        for (int k = 1; k <= 4; k++) if (m[(c + k) % 4]) return (c + k) % 4;
        return c;
    endfunction

    function automatic int ch_of(input logic [3:0] v);
        for (int k = 0; k < 4; k++) if (v[k]) return k;
        return 0;
    endfunction

    function automatic int cnt_addr(input int from, input logic [15:0] ad);
        int n = 0;
        for (int i = from; i < log_a.size(); i++) if (log_a[i].addr == ad) n++;
        return n;
    endfunction

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_log(input int n, input int budget, input string tag);
        int t = 0;
        while (log_a.size() < n && t < budget) begin tick(); t++; end
        chk(tag, 32'(log_a.size() >= n), 32'd1);
    endtask

    task automatic wait_valid(input int n, input int budget, input string tag);
        int t = 0;
        while (vq_a.size() < n && t < budget) begin tick(); t++; end
        chk(tag, 32'(vq_a.size() >= n), 32'd1);
    endtask

    task automatic chk_ex(input string tag, input int i, input logic [15:0] ad, input logic rh);
        chk({tag, "_addr"}, 32'(log_a[i].addr), 32'(ad));
        chk({tag, "_rh"}, 32'(log_a[i].rh), 32'(rh));
    endtask

    initial begin
        int m, t, t0, c, v0, a0, ri, lr;
        logic [7:0] dv;
        rst_n = 1'b0; dac_req = 1'b0; dac_data = 8'h00; b_req = 1'b0; b_dac = 8'h00;
        a_done = 1'b0; a_rd = 8'h00; b_done = 1'b0; b_rd = 8'h00;
        ain[0] = 8'h11; ain[1] = 8'h22; ain[2] = 8'h33; ain[3] = 8'h44;
        for (int i = 0; i < 4; i++) bin[i] = 8'($urandom);
        repeat (3) tick();
        chk("rst_exec", 32'(a_exec), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_addr", 32'(a_addr), 32'd0);
        chk("rst_adc", a_adc, 32'd0);
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_ack", 32'(a_ack), 32'd0);
        chk("rst_to", 32'(a_to), 32'd0);
        rst_n = 1'b1;

        wait_log(8, 600, "scan_execs");
        for (int i = 0; i < 8; i++) chk_ex($sformatf("scan%0d", i), i, 16'h40 + 16'(i / 2), 1'b1);
        wait_valid(4, 600, "scan_valids");
        for (int i = 0; i < 4; i++) chk($sformatf("scan_vorder%0d", i), 32'(vq_a[i]), 32'd1 << i);
        chk("scan_adc", a_adc, 32'h44332211);

        for (int i = 0; i < 4; i++) ain[i] = 8'($urandom);
        wait_valid(8, 600, "rand_valids");
        chk("rand_adc", a_adc, {ain[3], ain[2], ain[1], ain[0]});

        ain[1] = 8'($urandom);
        m = log_a.size(); t = 0;
        while (cnt_addr(m, 16'h41) < 2 && t < 600) begin tick(); t++; end
        chk("dac_sync", 32'(cnt_addr(m, 16'h41) >= 2), 32'd1);
        ri = log_a.size() - 1;
        dv = 8'($urandom);
        dac_req = 1'b1; dac_data = dv; a0 = ack_a; t = 0;
        while (ack_a == a0 && t < 400) begin tick(); t++; end
        dac_req = 1'b0;
        chk("dac_ack_seen", 32'(ack_a - a0), 32'd1);
        chk("dac_ch1_data", 32'(a_adc[15:8]), 32'(ain[1]));
        wait_log(ri + 3, 400, "dac_execs");
        chk_ex("dac_rd1", ri, 16'h41, 1'b1);
        chk_ex("dac_wr", ri + 1, 16'h40, 1'b0);
        chk("dac_wr_data", 32'(log_a[ri + 1].dw), 32'(dv));
        chk_ex("dac_next", ri + 2, 16'h42, 1'b1);
        chk("dac_ack_once", 32'(ack_a - a0), 32'd1);

        v0 = vq_a.size();
        wait_valid(v0 + 1, 400, "hold_sync");
        c = ch_of(vq_a[v0]);
        dv = 8'($urandom);
        dac_req = 1'b1; dac_data = dv;
        m = log_a.size();
        wait_log(m + 9, 900, "hold_execs");
        dac_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            c = nxt(c, 4'hF);
            chk_ex($sformatf("hold_wr%0d", k), m + 3 * k, 16'h40, 1'b0);
            chk($sformatf("hold_wd%0d", k), 32'(log_a[m + 3 * k].dw), 32'(dv));
            chk_ex($sformatf("hold_d%0d", k), m + 3 * k + 1, 16'h40 + 16'(c), 1'b1);
            chk_ex($sformatf("hold_r%0d", k), m + 3 * k + 2, 16'h40 + 16'(c), 1'b1);
        end

        v0 = vq_a.size();
        wait_valid(v0 + 1, 400, "to_sync");
        c = nxt(ch_of(vq_a[v0]), 4'hF);
        ain[c] = 8'($urandom);
        chk("to_pre", 32'(a_to), 32'd0);
        hold = 1'b1;
        m = log_a.size(); v0 = vq_a.size(); a0 = ack_a;
        wait_log(m + 1, 200, "to_exec");
        chk_ex("to_dummy", m, 16'h40 + 16'(c), 1'b1);
        t0 = log_a[m].cyc; t = 0;
        while (!a_to && t < 200) begin tick(); t++; end
        chk("to_delay", 32'(cyc - t0), 32'd50);
        chk("to_busy", 32'(a_busy), 32'd0);
        chk("to_novalid", 32'(vq_a.size() - v0), 32'd0);
        chk("to_noack", 32'(ack_a - a0), 32'd0);
        hold = 1'b0;
        wait_log(m + 3, 400, "to_retry");
        chk_ex("to_retry_d", m + 1, 16'h40 + 16'(c), 1'b1);
        chk_ex("to_retry_r", m + 2, 16'h40 + 16'(c), 1'b1);
        wait_valid(v0 + 1, 400, "to_valid");
        chk("to_valid_ch", 32'(vq_a[v0]), 32'd1 << c);
        chk("to_data", 32'(a_adc[8 * c +: 8]), 32'(ain[c]));
        chk("to_sticky", 32'(a_to), 32'd1);
        chk("b_adc", b_adc, {bin[3], 8'h00, bin[1], 8'h00});

        lat = 5;
        m = log_a.size();
        wait_log(m + 1, 200, "rst_sync");
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_exec", 32'(a_exec), 32'd0);
        chk("mid_busy", 32'(a_busy), 32'd0);
        chk("mid_addr", 32'(a_addr), 32'd0);
        chk("mid_dw", 32'(a_dw), 32'd0);
        chk("mid_adc", a_adc, 32'd0);
        chk("mid_to", 32'(a_to), 32'd0);
        lr = log_a.size(); v0 = vq_a.size(); a0 = ack_a;
        repeat (12) tick();
        chk("stale_valid", 32'(vq_a.size() - v0), 32'd0);
        chk("stale_ack", 32'(ack_a - a0), 32'd0);
        chk("stale_adc", a_adc, 32'd0);
        wait_log(lr + 1, 200, "post_exec");
        chk_ex("post_first", lr, 16'h40, 1'b1);
        wait_valid(v0 + 1, 400, "post_valid");
        chk("post_valid_ch", 32'(vq_a[v0]), 32'd1);
        chk("post_adc", a_adc, {24'h0, ain[0]});

        for (int i = 0; i < 8; i++)
            chk($sformatf("b_addr%0d", i), 32'(log_b[i].addr), (i % 4 < 2) ? 32'h41 : 32'h43);
        chk("b_v0", 32'(bv_cnt[0]), 32'd0);
        chk("b_v2", 32'(bv_cnt[2]), 32'd0);
        chk("b_v1_seen", 32'(bv_cnt[1] > 0), 32'd1);
        chk("b_v3_seen", 32'(bv_cnt[3] > 0), 32'd1);
        chk("a_protocol", 32'(bad_a), 32'd0);
        chk("b_protocol", 32'(bad_b), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
